// File: rtl/fifo_lifo_pkg.sv
// fifo_lifo_pkg: mode encodings and count-width helper shared by the buffer files
package fifo_lifo_pkg;
  localparam logic MODE_FIFO = 1'b0;
  localparam logic MODE_LIFO = 1'b1;
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/buf_mem_2p.sv
// buf_mem_2p: WIDTH x DEPTH register array, one write port, one registered read port
module buf_mem_2p #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;
  // storage array is never reset; its contents are meaningless until written
  always_ff @(posedge clk_i)
    if (we_i) mem_q[waddr_i] <= wdata_i;
  // read register samples the pre-write word, so a same-address write+read returns the old value
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  assign rdata_o = rdata_q;
endmodule

// File: rtl/fifo_lifo_param.sv
// fifo_lifo_param: run-time selectable FIFO/LIFO buffer with occupancy flags and sticky errors
module fifo_lifo_param import fifo_lifo_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1,
  localparam int CW = cnt_w(DEPTH)
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Mode,
  input  logic [WIDTH-1:0] Datain,
  input  logic             Wren,
  input  logic             Rden,
  output logic [WIDTH-1:0] Dataout,
  output logic             Valid,
  output logic             Full,
  output logic             Empty,
  output logic             Almost_full,
  output logic             Almost_empty,
  output logic             Overflow,
  output logic             Underflow,
  output logic [CW-1:0]    Count,
  output logic             Cur_mode
);
  localparam int AW = $clog2(DEPTH);
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, waddr, raddr, top;
  logic cur_mode_q, cur_mode_d, valid_q, ovf_q, ovf_d, udf_q, udf_d;
  logic full, empty, lifo, wr_acc, rd_acc;
  // accept decisions, addressing and next state; the stack pointer is the count itself
  always_comb begin
    full = count_q == CW'(DEPTH);
    empty = count_q == '0;
    lifo = cur_mode_q == MODE_LIFO;
    wr_acc = Wren && (!full || (Rden && lifo));
    rd_acc = Rden && !empty;
    top = AW'(count_q - CW'(1));
    waddr = lifo ? (rd_acc ? top : AW'(count_q)) : wptr_q;
    raddr = lifo ? top : rptr_q;
    wptr_d = (wr_acc && !lifo) ? (wptr_q == AW'(DEPTH - 1) ? '0 : wptr_q + AW'(1)) : wptr_q;
    rptr_d = (rd_acc && !lifo) ? (rptr_q == AW'(DEPTH - 1) ? '0 : rptr_q + AW'(1)) : rptr_q;
    count_d = count_q + CW'(wr_acc) - CW'(rd_acc);
    cur_mode_d = (empty && !Wren) ? Mode : cur_mode_q;
    ovf_d = ovf_q || (Wren && !wr_acc);
    udf_d = udf_q || (Rden && empty);
  end
  // control state; reset discards all held data at once
  always_ff @(posedge Clk or posedge Rst)
    if (Rst) begin
      count_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cur_mode_q <= MODE_FIFO;
      valid_q <= 1'b0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      count_q <= count_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cur_mode_q <= cur_mode_d;
      valid_q <= rd_acc;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  buf_mem_2p #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk_i(Clk),
    .rst_i(Rst),
    .we_i(wr_acc),
    .waddr_i(waddr),
    .wdata_i(Datain),
    .re_i(rd_acc),
    .raddr_i(raddr),
    .rdata_o(Dataout)
  );
  assign Valid = valid_q;
  assign Full = full;
  assign Empty = empty;
  assign Almost_full = int'(count_q) >= AF_LEVEL;
  assign Almost_empty = int'(count_q) <= AE_LEVEL;
  assign Overflow = ovf_q;
  assign Underflow = udf_q;
  assign Count = count_q;
  assign Cur_mode = cur_mode_q;
endmodule

// File: tb/tb_fifo_lifo_param.sv
// tb_fifo_lifo_param: table vectors, corner sequences and random traffic against a queue model
module tb_fifo_lifo_param;
  localparam int D = 8;
  logic clk = 0, rst = 0, mode = 0, wren = 0, rden = 0;
  logic [31:0] din = 0, dout;
  logic valid, full, empty, afull, aempty, ovf, udf, cmode;
  logic [3:0] count;
  int n_vec = 0, n_bad = 0;
  logic [31:0] mq[$];
  logic [31:0] md;
  bit mv, mo, mu, mm;

  fifo_lifo_param #(.WIDTH(32), .DEPTH(D), .AF_LEVEL(6), .AE_LEVEL(2)) dut (
    .Clk(clk), .Rst(rst), .Mode(mode), .Datain(din), .Wren(wren), .Rden(rden),
    .Dataout(dout), .Valid(valid), .Full(full), .Empty(empty), .Almost_full(afull),
    .Almost_empty(aempty), .Overflow(ovf), .Underflow(udf), .Count(count), .Cur_mode(cmode)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit mode, wr, rd;
    logic [31:0] din, dout;
    bit valid;
    int cnt;
  } vec_t;
  vec_t tv[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    md = 0; mv = 0; mo = 0; mu = 0; mm = 0;
  endtask

  task automatic model_edge(input bit m, input bit wr, input bit rd, input logic [31:0] d);
    bit fl, em, wa, ra;
    fl = mq.size() == D;
    em = mq.size() == 0;
    wa = wr && (!fl || (rd && mm));
    ra = rd && !em;
    mv = ra;
    if (ra) md = mm ? mq.pop_back() : mq.pop_front();
    if (wa) mq.push_back(d);
    if (wr && !wa) mo = 1;
    if (rd && em) mu = 1;
    if (em && !wr) mm = m;
  endtask

  task automatic check_all();
    chk("dataout", dout, md);
    chk("valid", 32'(valid), 32'(mv));
    chk("count", 32'(count), mq.size());
    chk("full", 32'(full), 32'(mq.size() == D));
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("almost_full", 32'(afull), 32'(mq.size() >= 6));
    chk("almost_empty", 32'(aempty), 32'(mq.size() <= 2));
    chk("overflow", 32'(ovf), 32'(mo));
    chk("underflow", 32'(udf), 32'(mu));
    chk("cur_mode", 32'(cmode), 32'(mm));
  endtask

  task automatic step(input bit m, input bit wr, input bit rd, input logic [31:0] d);
    @(negedge clk);
    mode = m; wren = wr; rden = rd; din = d;
    @(posedge clk);
    model_edge(m, wr, rd, d);
    #1 check_all();
  endtask

  task automatic do_reset(input bit m);
    @(negedge clk);
    mode = m; wren = 0; rden = 0;
    rst = 1;
    model_reset();
    #1 check_all();
    #2 rst = 0;
  endtask

  task automatic add(input bit m, input bit wr, input bit rd, input logic [31:0] d,
                     input logic [31:0] q, input bit v, input int c);
    vec_t t;
    t.mode = m; t.wr = wr; t.rd = rd; t.din = d; t.dout = q; t.valid = v; t.cnt = c;
    tv.push_back(t);
  endtask

  initial begin
    add(0,1,0,20, 0,0,1); add(0,1,0,10, 0,0,2); add(0,1,0,30, 0,0,3);
    add(0,1,0,40, 0,0,4); add(0,1,0,50, 0,0,5);
    add(0,0,1,0, 20,1,4); add(0,0,1,0, 10,1,3); add(0,0,1,0, 30,1,2);
    add(0,0,1,0, 40,1,1); add(0,0,1,0, 50,1,0);
    add(1,0,0,0, 50,0,0);
    add(1,1,0,20, 50,0,1); add(1,1,0,10, 50,0,2); add(1,1,0,30, 50,0,3);
    add(1,1,0,40, 50,0,4); add(1,1,0,50, 50,0,5);
    add(1,0,1,0, 50,1,4); add(1,0,1,0, 40,1,3); add(1,0,1,0, 30,1,2);
    add(1,0,1,0, 10,1,1); add(1,0,1,0, 20,1,0); add(1,0,1,0, 20,0,0);

    do_reset(0);
    foreach (tv[i]) begin
      step(tv[i].mode, tv[i].wr, tv[i].rd, tv[i].din);
      chk($sformatf("tv%0d_dout", i), dout, tv[i].dout);
      chk($sformatf("tv%0d_valid", i), 32'(valid), 32'(tv[i].valid));
      chk($sformatf("tv%0d_count", i), 32'(count), tv[i].cnt);
    end
    chk("lifo_underflow", 32'(udf), 1);
    step(1, 0, 0, 0);
    chk("underflow_sticky", 32'(udf), 1);

    do_reset(0);
    for (int i = 1; i <= 9; i++) begin
      step(0, 1, 0, i);
      if (i == 8) chk("full_after_8", 32'(full), 1);
    end
    chk("overflow_9th", 32'(ovf), 1);
    chk("count_capped", 32'(count), 8);
    for (int i = 1; i <= 8; i++) begin
      step(0, 0, 1, 0);
      chk("fifo_full_drain", dout, i);
    end

    do_reset(0);
    for (int i = 1; i <= 3; i++) step(0, 1, 0, i);
    step(0, 1, 1, 7);
    chk("fifo_rw_dout", dout, 1);
    chk("fifo_rw_count", 32'(count), 3);

    do_reset(1);
    step(1, 0, 0, 0);
    for (int i = 1; i <= 8; i++) step(1, 1, 0, i);
    step(1, 1, 1, 99);
    chk("lifo_rw_dout", dout, 8);
    chk("lifo_rw_count", 32'(count), 8);
    chk("lifo_rw_no_ovf", 32'(ovf), 0);
    step(1, 0, 1, 0);
    chk("lifo_rw_pop", dout, 99);

    do_reset(0);
    for (int i = 1; i <= 6; i++) begin
      step(0, 1, 0, i);
      if (i == 2) chk("ae_at_2", 32'(aempty), 1);
      if (i == 3) chk("ae_at_3", 32'(aempty), 0);
      if (i == 5) chk("af_at_5", 32'(afull), 0);
      if (i == 6) chk("af_at_6", 32'(afull), 1);
    end
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("mode_locked", 32'(cmode), 0);
    for (int i = 0; i < 3; i++) step(1, 0, 1, 0);
    step(1, 0, 0, 0);
    chk("mode_follows", 32'(cmode), 1);

    do_reset(0);
    step(0, 0, 1, 0);
    for (int i = 1; i <= 5; i++) step(0, 1, 0, 32'h100 + i);
    step(0, 0, 1, 0);
    chk("pre_rst_count", 32'(count), 4);
    chk("pre_rst_valid", 32'(valid), 1);
    #2 rst = 1;
    model_reset();
    #1;
    chk("async_count", 32'(count), 0);
    chk("async_empty", 32'(empty), 1);
    chk("async_valid", 32'(valid), 0);
    chk("async_udf", 32'(udf), 0);
    check_all();
    @(negedge clk) rst = 0;
    step(0, 0, 1, 0);
    chk("post_rst_udf", 32'(udf), 1);
    chk("post_rst_valid", 32'(valid), 0);

    do_reset(0);
    begin
      bit m = 0;
      for (int i = 0; i < 600; i++) begin
        if ($urandom_range(0, 15) == 0) m = ~m;
        step(m, $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45, $urandom);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/fifo_lifo_param.md
Name: fifo_lifo_param

Overview:
Parametrised synchronous buffer that operates as a FIFO or as a LIFO (stack), selected at run time. It is the successor to the fixed 32-bit FIFO/LIFO, adding:
- configurable width and depth
- registered read data with a valid strobe
- occupancy count and programmable almost-full/almost-empty flags
- sticky overflow/underflow error flags
It sits between a producer and a consumer in the datapath and uses the same Datain/Wren/Rden handshake as the existing buffer.

Parameters:
WIDTH, 32, data word width in bits (>=1)
DEPTH, 8, number of entries (>=2, power of two not required)
AF_LEVEL, DEPTH-1, Almost_full asserts when Count >= AF_LEVEL
AE_LEVEL, 1, Almost_empty asserts when Count <= AE_LEVEL
CW, $clog2(DEPTH+1), Count width (derived, not overridden)

Ports:
Clk  input  1  single clock, rising edge
Rst  input  1  reset, asynchronous, active-high
Mode  input  1  0 = FIFO, 1 = LIFO (requested mode)
Datain  input  WIDTH  write data
Wren  input  1  write request
Rden  input  1  read request
Dataout  output  WIDTH  registered read data
Valid  output  1  one-cycle pulse: Dataout holds a newly read word
Full  output  1  Count == DEPTH
Empty  output  1  Count == 0
Almost_full  output  1  Count >= AF_LEVEL
Almost_empty  output  1  Count <= AE_LEVEL
Overflow  output  1  sticky: a write was rejected while full
Underflow  output  1  sticky: a read was rejected while empty
Count  output  CW  current occupancy 0..DEPTH
Cur_mode  output  1  mode currently in effect

Behaviour:
- Reset (async assert, sync release). Every output is 0 except Empty=1 and Almost_empty=1. Specifically: Dataout=0, Valid=0, Count=0, Full=0, Almost_full=0 (when AF_LEVEL>0), Overflow=0, Underflow=0. Cur_mode=Mode as sampled on the first clock after release. Pointers=0. Memory contents are don't-care.
- Reset mid-operation: all stored data is discarded immediately. The first read after reset is an underflow.
- Mode handling: Cur_mode loads Mode on a clock edge only when Count==0 and Wren==0. Mode changes while data is held are ignored until the buffer drains.
- Write accept: Wren && (!Full || (Rden && Cur_mode==LIFO)). A write while full with no same-cycle LIFO read is dropped and sets Overflow. In FIFO mode a write while full is always rejected, even with a concurrent read.
- Read accept: Rden && !Empty. A read while empty sets Underflow, and Valid stays 0.
- Read latency: 1 cycle. The accepted read at edge N drives Dataout and Valid=1 after edge N. Dataout holds its last value when there is no read.
- FIFO: separate write/read pointers wrap from DEPTH-1 to 0. Order is preserved. With a simultaneous accepted read and write, Count is unchanged. The read returns the oldest entry, never the word being written.
- LIFO: a single stack pointer sp = Count; the top entry is mem[sp-1].
  - Push writes mem[sp] and sets sp+1.
  - Pop returns mem[sp-1] and sets sp-1.
  - Simultaneous push and pop: Dataout = old mem[sp-1], mem[sp-1] = Datain, sp unchanged. This is legal when full.
  - Simultaneous push and pop when empty: the pop underflows and the push is accepted.
- Count: +1 on write only, -1 on read only, unchanged otherwise. It never exceeds DEPTH and never wraps below 0.
- All flags are derived from the registered Count and are valid in the same cycle as Count.
- Overflow and Underflow are cleared only by Rst.

Decomposition:
- Shared package fifo_lifo_pkg holds:
  - MODE_FIFO=1'b0 and MODE_LIFO=1'b1 constants
  - a function computing the Count width
- One natural sub-module: buf_mem_2p. It is a WIDTH x DEPTH register array with one write port and one registered read port, with no reset on the array.
- Pointer, count, flag and mode logic live in fifo_lifo_param.

Test Plan:
- FIFO order (WIDTH=32, DEPTH=8, Mode=0): pulse Rst, write 20,10,30,40,50 on consecutive cycles, then read 5 → Dataout 20,10,30,40,50, each with Valid=1 one cycle after Rden. Count steps 5→0, Empty=1 at the end.
- LIFO order (Mode=1): same writes, then read 5 → Dataout 50,40,30,10,20. Reading a 6th time → Valid=0, Underflow=1 and stays set.
- Full/overflow, FIFO: write 9 words 1..9 → Full=1 after the 8th, the 9th is dropped, Overflow=1. Reading 8 times returns 1..8.
- Simultaneous R/W:
  - FIFO holding {1,2,3}: Wren+Rden with Datain=7 → Dataout=1, Count stays 3.
  - LIFO full with top=8: Wren+Rden with Datain=99 → Dataout=8, Count=8, the next pop returns 99.
- Thresholds and mode lock: AF_LEVEL=6, AE_LEVEL=2. Almost_full rises at Count=6 and Almost_empty falls at Count=3. Toggling Mode while Count=3 leaves Cur_mode unchanged; after draining to 0, Cur_mode follows Mode.
- Async reset mid-burst: assert Rst between clock edges while Count=4 → Count=0, Empty=1, Valid=0, and flags are cleared immediately without waiting for a clock edge.
